// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU, CLS_LOAD, CLS_BRANCH
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic IMM_I = 1'b1;
    localparam logic IMM_B = 1'b0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct fields to ALU/immediate
// controls, instruction class and an unsupported-encoding flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_ctrl,
    output logic       o_imm_src,
    output logic       o_alu_src,
    output iclass_t    o_iclass,
    output logic       o_illegal
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_imm_src  = IMM_B;
        o_alu_src  = 1'b0;
        o_iclass   = CLS_ALU;
        o_illegal  = 1'b0;
        case (i_opcode)
            OP_R: begin
                case (i_funct3)
                    3'b000:  o_alu_ctrl = i_funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  o_alu_ctrl = ALU_AND;
                    3'b110:  o_alu_ctrl = ALU_OR;
                    default: o_illegal  = 1'b1;
                endcase
            end
            OP_I: begin
                o_imm_src = IMM_I;
                o_alu_src = 1'b1;
                case (i_funct3)
                    3'b000:  o_alu_ctrl = ALU_ADD;
                    3'b111:  o_alu_ctrl = ALU_AND;
                    3'b110:  o_alu_ctrl = ALU_OR;
                    default: o_illegal  = 1'b1;
                endcase
            end
            OP_LOAD: begin
                o_imm_src = IMM_I;
                o_alu_src = 1'b1;
                o_iclass  = CLS_LOAD;
                o_illegal = (i_funct3 != 3'b010);
            end
            OP_BRANCH: begin
                // beq/bne only; compare is a subtract feeding EQ
                o_alu_ctrl = ALU_SUB;
                o_iclass   = CLS_BRANCH;
                o_illegal  = (i_funct3[2:1] != 2'b00);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb sequencing over a shared
// memory port, branch-taken flop and retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  EQ,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_sel,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  PCsrc,
    output logic                  ImmSrc,
    output logic                  ALUsrc,
    output logic [2:0]            ALUctrl,
    output logic                  RegWrite,
    output logic                  ResultSrc,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  retired
);

    state_t               r_state, w_next;
    logic                 r_taken, r_is_load, r_imm_src;
    logic [2:0]           r_alu_ctrl;
    logic [CNT_WIDTH-1:0] r_retired;

    logic [2:0] w_alu_ctrl;
    logic       w_imm_src, w_alu_src, w_illegal;
    iclass_t    w_iclass;
    logic       w_unused;

    assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

    ctrl_decode u_dec (
        .i_opcode   (instr[6:0]),
        .i_funct3   (instr[14:12]),
        .i_funct7b5 (instr[30]),
        .o_alu_ctrl (w_alu_ctrl),
        .o_imm_src  (w_imm_src),
        .o_alu_src  (w_alu_src),
        .o_iclass   (w_iclass),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // EXEC values are captured so MEM/WB keep the datapath stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_taken    <= 1'b0;
            r_is_load  <= 1'b0;
            r_imm_src  <= 1'b0;
            r_alu_ctrl <= ALU_ADD;
            r_retired  <= '0;
        end else begin
            if (r_state == S_EXEC) begin
                r_imm_src  <= w_imm_src;
                r_alu_ctrl <= w_alu_ctrl;
                r_is_load  <= (w_iclass == CLS_LOAD);
                if (w_iclass == CLS_BRANCH)
                    r_taken <= EQ ^ instr[12];  // funct3[0]: 0 beq, 1 bne
            end
            if (pc_write)
                r_retired <= r_retired + CNT_WIDTH'(1);
        end
    end

    assign retired = r_retired;

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_sel   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        PCsrc     = 1'b0;
        ImmSrc    = 1'b0;
        ALUsrc    = 1'b0;
        ALUctrl   = 3'b000;
        RegWrite  = 1'b0;
        ResultSrc = 1'b0;
        illegal   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                ImmSrc  = w_imm_src;
                ALUsrc  = w_alu_src;
                ALUctrl = w_alu_ctrl;
                case (w_iclass)
                    CLS_LOAD:   w_next = S_MEM;
                    CLS_BRANCH: w_next = S_BR;
                    default:    w_next = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                ImmSrc  = r_imm_src;
                ALUctrl = r_alu_ctrl;
                if (mem_ready) w_next = S_WB;
            end
            S_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = r_is_load;
                pc_write  = 1'b1;
                ImmSrc    = r_imm_src;
                ALUctrl   = r_alu_ctrl;
                w_next    = S_FETCH;
            end
            S_BR: begin
                pc_write = 1'b1;
                PCsrc    = r_taken;
                w_next   = S_FETCH;
            end
            S_TRAP:  illegal = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I subset core.
- Sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port.
- Drives the immediate-select line (ImmSrc), the ALU operand mux, ALU control, register write, and PC update.
- Sits between the instruction register and the datapath (sign extender, ALU, register file, PC). Also counts retired instructions.

Parameters:
- DATA_WIDTH, 32: instruction width. Fixed at 32 for RV32I.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  DATA_WIDTH  instruction register contents; valid from DECODE onwards.
- EQ  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_sel  out  1  memory address select: 0 = PC (instruction), 1 = ALU result (data).
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- PCsrc  out  1  0 = PC+4, 1 = PC+ImmOp.
- ImmSrc  out  1  1 = I-type immediate, 0 = B-type immediate.
- ALUsrc  out  1  0 = register operand, 1 = ImmOp.
- ALUctrl  out  3  ALU operation code.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  1  0 = ALU result, 1 = memory data.
- illegal  out  1  sticky: unsupported instruction was decoded.
- retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BR, TRAP. State register is async-reset to IDLE.
- While rst is low:
  - All outputs are 0.
  - retired is 0; illegal is 0; the taken flop is 0.
- IDLE: all outputs 0. Go to FETCH unconditionally on the next edge.
- FETCH:
  - mem_req=1, mem_sel=0.
  - ir_write = mem_ready.
  - Stay while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE: registers are read. Decode instr[6:0]:
  - 0110011 (R-type), 0010011 (I-ALU), 0000011 (load, funct3=010 only), 1100011 (branch, funct3 000/001) → EXEC.
  - Any other opcode or funct → TRAP.
- EXEC:
  - ImmSrc=1 for I-ALU and load; ImmSrc=0 for branch.
  - ALUsrc=1 for I-ALU and load; ALUsrc=0 otherwise.
  - ALUctrl per the decode table below.
  - Branch only: taken flop <= EQ for beq, ~EQ for bne.
  - Next state: load → MEM; branch → BR; otherwise → WB.
- ALU decode table:
  - add: addi, load address, R-type add.
  - sub: R-type with funct7[5]=1, and branch compare.
  - and: funct3=111.
  - or: funct3=110.
  - Any other funct3 → TRAP.
- ImmSrc and ALUctrl hold their EXEC values through MEM and WB, so the datapath stays stable.
- MEM:
  - mem_req=1, mem_sel=1.
  - Stay while mem_ready=0. Go to WB when mem_ready=1.
- WB:
  - RegWrite=1; ResultSrc=1 for load only.
  - pc_write=1, PCsrc=0.
  - Next state FETCH.
- BR:
  - pc_write=1, PCsrc=taken.
  - Next state FETCH.
- TRAP:
  - illegal=1; all other outputs 0.
  - Absorbing until reset.
- retired increments by 1 on every edge where pc_write=1. It wraps modulo 2^CNT_WIDTH.
- Latency with zero wait states: R/I-ALU 4 cycles, branch 4, load 5. Each mem_ready=0 cycle adds one cycle.
- mem_ready asserted outside FETCH and MEM is ignored.
- Reset asserted mid-instruction:
  - FSM returns to IDLE immediately.
  - No partial RegWrite or pc_write is issued.
  - retired holds 0 until reset releases.
- pc_write and RegWrite are never both 1 outside WB.
- ir_write is never 1 outside FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum.
  - Opcode constants: OP_R, OP_I, OP_LOAD, OP_BRANCH.
  - ALUctrl constants: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011.
  - IMM_I=1, IMM_B=0.
- One sub-module, ctrl_decode (combinational): maps opcode/funct3/funct7 to ALUctrl, ImmSrc, ALUsrc, instruction class and an illegal flag.
- FSM, taken flop and counter live in multicycle_ctrl.

Test Plan:
- Reset release, mem_ready=1, instr=addi x1,x0,5 (0x00500093) → IDLE,FETCH,DECODE,EXEC,WB; ImmSrc=1, ALUsrc=1, ALUctrl=000 in EXEC; RegWrite=1 and pc_write=1 in WB; retired=1.
- beq with EQ=1 (0x00208463) → EXEC ImmSrc=0, ALUctrl=001; BR PCsrc=1. Repeat with EQ=0 → PCsrc=0. RegWrite=0 throughout.
- lw (0x0000A103) with mem_ready low 3 cycles in MEM → MEM held 4 cycles, mem_sel=1; WB ResultSrc=1; total 8 cycles.
- Opcode 0x7F in instr → TRAP after DECODE, illegal=1, no pc_write. Stays through 10 cycles; reset clears it.
- rst low during MEM of a load → outputs 0 asynchronously; after release, FETCH begins with no RegWrite pulse; retired=0.
- Run 2^CNT_WIDTH addi instructions (CNT_WIDTH=4 override) → retired wraps 15→0.
